// File: rtl/interconnect_pkg.sv
// Shared definitions for the serial interconnect (injector, node, receiver).
// Frame layout, MSB first: {dest[IP_WIDTH-1:0], src[IP_WIDTH-1:0], payload}.
// Header offsets are counted down from the frame MSB.
package interconnect_pkg;
  localparam int IP_WIDTH  = 3;
  localparam int HDR_WIDTH = 2 * IP_WIDTH;
  localparam int DEST_OFS  = 0;
  localparam int SRC_OFS   = IP_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } link_state_e;
endpackage

// File: rtl/injector_fifo.sv
// Small synchronous FIFO holding host packets waiting to be serialised.
// Ports:
//   clk, rst_n        clock, async active-low reset (empties the FIFO)
//   push, wdata       write strobe/data (caller only pushes when not_full)
//   pop, rdata        read strobe, head-of-queue data (valid when not_empty)
//   not_full          registered occupancy < DEPTH
//   not_empty         registered occupancy != 0
//   not_empty_d       occupancy after this edge != 0 (for registered status)
module injector_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             not_full,
  output logic             not_empty,
  output logic             not_empty_d
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: contents are only read when occupancy says so.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata       = mem_q[rd_ptr_q];
  assign not_full    = (cnt_q < CNT_W'(DEPTH));
  assign not_empty   = (cnt_q != '0);
  assign not_empty_d = (cnt_d != '0);
endmodule

// File: rtl/node_packet_injector.sv
// Host-side packet injector: buffers host packets, prepends the
// {dest, src} header and shifts frames MSB-first into a node's serial input.
// Ports:
//   shiftInCLK, resetN     clock, async active-low reset
//   txValid/txReady        host handshake; txDest, txPayload packet fields
//   linkHold               node busy; only blocks the start of a frame
//   shiftOutData/CS        serial data and frame enable to the node
//   txDropSelf             pulse: a self-addressed packet was discarded
//   sentCount              completed frames (8-bit, wraps)
//   busy                   FSM not idle or FIFO non-empty
module node_packet_injector import interconnect_pkg::*; #(
  parameter logic [IP_WIDTH-1:0] NODE_IP = 3'b000,
  parameter int PACKET_WIDTH = 16,
  parameter int GAP_CYCLES   = 1,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic                             shiftInCLK,
  input  logic                             resetN,
  input  logic                             txValid,
  input  logic [IP_WIDTH-1:0]              txDest,
  input  logic [PACKET_WIDTH-HDR_WIDTH-1:0] txPayload,
  output logic                             txReady,
  input  logic                             linkHold,
  output logic                             shiftOutData,
  output logic                             shiftOutCS,
  output logic                             txDropSelf,
  output logic [7:0]                       sentCount,
  output logic                             busy
);
  localparam int PAY_W = PACKET_WIDTH - HDR_WIDTH;
  localparam int CNT_W = $clog2(PACKET_WIDTH + GAP_CYCLES + 1);

  link_state_e             state_q, state_d;
  logic [PACKET_WIDTH-1:0] shreg_q, shreg_d, frame, head;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [7:0]              sent_q, sent_d;
  logic cs_q, cs_d, data_q, data_d, drop_q, drop_d, busy_q, busy_d;
  logic accept, self_addr, push, pop, fifo_not_empty, fifo_not_empty_d;

  assign accept    = txValid && txReady;
  assign self_addr = (txDest == NODE_IP);
  assign push      = accept && !self_addr;

  always_comb begin
    frame = '0;
    frame[PACKET_WIDTH-1-DEST_OFS -: IP_WIDTH] = txDest;
    frame[PACKET_WIDTH-1-SRC_OFS  -: IP_WIDTH] = NODE_IP;
    frame[PAY_W-1:0] = txPayload;
  end

  injector_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PACKET_WIDTH)) u_fifo (
    .clk        (shiftInCLK),
    .rst_n      (resetN),
    .push       (push),
    .wdata      (frame),
    .pop        (pop),
    .rdata      (head),
    .not_full   (txReady),
    .not_empty  (fifo_not_empty),
    .not_empty_d(fifo_not_empty_d)
  );

  // cnt_q holds bits still to present in SHIFT, and remaining gap cycles in GAP.
  // The start edge presents the MSB directly from the FIFO head.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    sent_d  = sent_q;
    cs_d    = 1'b0;
    data_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fifo_not_empty && !linkHold) begin
          pop     = 1'b1;
          state_d = ST_SHIFT;
          cs_d    = 1'b1;
          data_d  = head[PACKET_WIDTH-1];
          shreg_d = head << 1;
          cnt_d   = CNT_W'(PACKET_WIDTH - 1);
        end
      end
      ST_SHIFT: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          sent_d  = sent_q + 8'd1;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
        end else begin
          cs_d    = 1'b1;
          data_d  = shreg_q[PACKET_WIDTH-1];
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    drop_d = accept && self_addr;
    busy_d = (state_d != ST_IDLE) || fifo_not_empty_d;
  end

  always_ff @(posedge shiftInCLK or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      sent_q  <= '0;
      cs_q    <= 1'b0;
      data_q  <= 1'b0;
      drop_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      sent_q  <= sent_d;
      cs_q    <= cs_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
      busy_q  <= busy_d;
    end
  end

  assign shiftOutCS   = cs_q;
  assign shiftOutData = data_q;
  assign txDropSelf   = drop_q;
  assign sentCount    = sent_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_node_packet_injector.sv
module tb_node_packet_injector;
  localparam int PW = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic       link_hold = 1'b0;
  logic [2:0] tx_dest = '0;
  logic [9:0] tx_payload = '0;
  logic       tx_ready, sdata, scs, drop, busy;
  logic [7:0] sent;

  always #5 clk = ~clk;

  node_packet_injector #(
    .NODE_IP(3'b000), .PACKET_WIDTH(PW), .GAP_CYCLES(1), .FIFO_DEPTH(2)
  ) dut (
    .shiftInCLK  (clk),
    .resetN      (rst_n),
    .txValid     (tx_valid),
    .txDest      (tx_dest),
    .txPayload   (tx_payload),
    .txReady     (tx_ready),
    .linkHold    (link_hold),
    .shiftOutData(sdata),
    .shiftOutCS  (scs),
    .txDropSelf  (drop),
    .sentCount   (sent),
    .busy        (busy)
  );

  typedef struct {
    logic [PW-1:0] word;
    int            nbits;
  } obs_t;

  obs_t          obs_q[$];
  logic [PW-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  // Frame monitor: collects each CS-high burst and records how many
  // CS-low cycles preceded every frame start.
  int            start_cnt = 0;
  int            gap_at[0:1023];
  logic          in_frame = 1'b0;
  int            nbits = 0;
  int            low_run = 0;
  logic [PW-1:0] word = '0;
  obs_t          mon_o;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
      nbits    = 0;
      low_run  = 0;
    end else if (scs) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        nbits    = 0;
        word     = '0;
        if (start_cnt < 1024) gap_at[start_cnt] = low_run;
        start_cnt++;
      end
      word = {word[PW-2:0], sdata};
      nbits++;
    end else begin
      if (in_frame) begin
        in_frame    = 1'b0;
        mon_o.word  = word;
        mon_o.nbits = nbits;
        obs_q.push_back(mon_o);
        low_run = 0;
      end
      low_run++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  // with txValid still high so packets can be offered back to back.
  task automatic offer(input logic [2:0] d, input logic [9:0] p, output int waited);
    waited     = 0;
    tx_valid   = 1'b1;
    tx_dest    = d;
    tx_payload = p;
    while (!tx_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check("offer_wait_bound", waited < 500, 1);
    @(posedge clk);
    if (d != 3'b000) exp_q.push_back({d, 3'b000, p});
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while ((busy || scs) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, n < limit, 1);
  endtask

  task automatic drain(input string tag);
    obs_t          o;
    logic [PW-1:0] e;
    check({tag, "_nframes"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_len"}, o.nbits, PW);
      check({tag, "_word"}, o.word, e);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int w;
    int s0;
    logic [PW-1:0] t1_word;

    // Reset state
    cycles(3);
    check("rst_cs", scs, 0);
    check("rst_data", sdata, 0);
    check("rst_drop", drop, 0);
    check("rst_sent", sent, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", tx_ready, 1);
    rst_n = 1'b1;
    cycles(2);

    // Single send: CS rises one edge after acceptance
    s0 = start_cnt;
    offer(3'b011, 10'h2A5, w);
    tx_valid = 1'b0;
    check("t1_cs_before", scs, 0);
    @(negedge clk);
    check("t1_cs_rise", scs, 1);
    check("t1_busy", busy, 1);
    wait_idle("t1_idle", 100);
    check("t1_sent", sent, 1);
    check("t1_nstart", start_cnt - s0, 1);
    t1_word = (obs_q.size() > 0) ? obs_q[0].word : 'x;
    check("t1_bits", t1_word, 16'b011_000_1010100101);
    drain("t1");

    // Back-to-back: hold fills the FIFO so the third packet must wait
    link_hold = 1'b1;
    s0 = start_cnt;
    offer(3'd1, 10'h111, w);
    offer(3'd2, 10'h222, w);
    check("t2_ready_full", tx_ready, 0);
    tx_dest    = 3'd3;
    tx_payload = 10'h333;
    cycles(3);
    check("t2_hold_nostart", start_cnt - s0, 0);
    check("t2_still_full", tx_ready, 0);
    link_hold = 1'b0;
    offer(3'd3, 10'h333, w);
    tx_valid = 1'b0;
    check("t2_third_waited", w > 0, 1);
    wait_idle("t2_idle", 200);
    check("t2_nstart", start_cnt - s0, 3);
    check("t2_gap1", gap_at[s0+1], 2);
    check("t2_gap2", gap_at[s0+2], 2);
    check("t2_sent", sent, 4);
    drain("t2");

    // Self-addressed packet is dropped
    s0 = start_cnt;
    offer(3'b000, 10'h155, w);
    tx_valid = 1'b0;
    check("t3_drop_hi", drop, 1);
    @(negedge clk);
    check("t3_drop_lo", drop, 0);
    cycles(20);
    check("t3_nostart", start_cnt - s0, 0);
    check("t3_sent", sent, 4);
    check("t3_busy", busy, 0);
    check("t3_ready", tx_ready, 1);
    drain("t3");

    // Hold: blocks start only; toggling mid-frame does not stretch it
    link_hold = 1'b1;
    s0 = start_cnt;
    offer(3'd5, 10'h0F0, w);
    tx_valid = 1'b0;
    cycles(10);
    check("t4_held_cs", scs, 0);
    check("t4_held_nostart", start_cnt - s0, 0);
    check("t4_held_busy", busy, 1);
    link_hold = 1'b0;
    @(negedge clk);
    check("t4_cs_rise", scs, 1);
    cycles(4);
    link_hold = 1'b1;
    cycles(3);
    link_hold = 1'b0;
    cycles(2);
    link_hold = 1'b1;
    offer(3'd6, 10'h00F, w);
    tx_valid = 1'b0;
    cycles(20);
    check("t4_second_held", start_cnt - s0, 1);
    check("t4_second_busy", busy, 1);
    link_hold = 1'b0;
    wait_idle("t4_idle", 100);
    check("t4_nstart", start_cnt - s0, 2);
    check("t4_sent", sent, 6);
    drain("t4");

    // Reset mid-frame at bit 7
    offer(3'd4, 10'h3C3, w);
    tx_valid = 1'b0;
    @(negedge clk);
    cycles(8);
    check("t5_in_frame", scs, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_cs_async", scs, 0);
    check("t5_sent_rst", sent, 0);
    cycles(2);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_ready", tx_ready, 1);
    check("t5_sent", sent, 0);
    check("t5_no_frame", obs_q.size(), 0);
    obs_q.delete();
    exp_q.delete();

    // Wrap: 256 frames bring sentCount back to 0
    s0 = start_cnt;
    for (int i = 0; i < 256; i++) begin
      offer(3'($urandom_range(1, 7)), 10'($urandom), w);
      if (i == 0) check("t6_sent_start", sent, 0);
    end
    tx_valid = 1'b0;
    wait_idle("t6_idle", 2000);
    check("t6_nstart", start_cnt - s0, 256);
    check("t6_sent_wrap", sent, 0);
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
